debug_trace_serializer: RTL and testbench
=========================================

DEBUG_TRACE_SERIALIZER -- requirements
Module: debug_trace_serializer

Interface
REQ-001 SHALL have parameter OUT_W, default 4: width of the serial output beat in bits; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of buffered trace records; power of two, at least 2.
REQ-003 SHALL have parameter DROP_W, default 16: width of the dropped-record counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 mode  input  2  format per record: 0 = PC only, 1 = PC+instr, 2 = PC+instr+wdata, 3 = same as 0.
REQ-007 debug_wb_pc  input  32  writeback PC.
REQ-008 debug_wb_instr  input  32  writeback instruction.
REQ-009 debug_wb_rf_wdata  input  32  writeback register-file write data.
REQ-010 data  output  OUT_W  serial trace beat.
REQ-011 frame  output  1  high only on the first beat of each record.
REQ-012 busy  output  1  high while a beat is being driven on data.
REQ-013 drop_cnt  output  DROP_W  count of records lost to a full FIFO.

Function
REQ-014 SHALL keep a last_pc register; a new PC event occurs in a cycle when debug_wb_pc != last_pc.
REQ-015 On every new PC event, last_pc SHALL load debug_wb_pc, whether the record is stored, dropped or ignored.
REQ-016 A new PC event with debug_wb_pc != 0 SHALL push one record {wdata, instr, pc, mode} sampled in that cycle.
REQ-017 A push SHALL be accepted when occupancy < FIFO_DEPTH, or when a pop happens in the same cycle.
REQ-018 A push that is not accepted SHALL be discarded and SHALL increment drop_cnt.
REQ-019 drop_cnt SHALL saturate at its all-ones value.
REQ-020 Record length in beats SHALL be N*32/OUT_W, where N = 1, 2 or 3 fields for mode 0/3, 1 or 2 respectively, using the record's latched mode.
REQ-021 Serialization SHALL be LSB-first over the concatenation {wdata, instr, pc}; beat k carries bits [k*OUT_W +: OUT_W].
REQ-022 The serializer SHALL have two states. IDLE goes to SEND when the FIFO is non-empty. SEND goes to IDLE after the last beat if the FIFO is then empty. Otherwise SEND stays in SEND with the next record.
REQ-023 A record pushed at edge t with the FIFO empty and the serializer in IDLE SHALL drive its beat 0 in the cycle after edge t (latency 1).
REQ-024 Back-to-back records SHALL have no gap: the beat after the last beat of a record SHALL be beat 0 of the next record.
REQ-025 The pop of a record SHALL occur on the edge that ends its last beat.
REQ-026 In IDLE, data, frame and busy SHALL all be 0.
REQ-027 Changes on mode, or on the debug_wb_* inputs, during SEND SHALL NOT alter the record being sent.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst_n = 0, the block SHALL asynchronously force data = 0, frame = 0, busy = 0, drop_cnt = 0, last_pc = 0, FIFO empty and state IDLE.
REQ-030 Assertion of rst_n mid-record SHALL abort the record with no partial beats after the release of reset.
REQ-031 Release of rst_n SHALL be synchronised; the first capture can occur on the first edge after release.

Verification (OUT_W = 4, FIFO_DEPTH = 4)
REQ-032 Scenario 1: pc = 0x1c000000, instr = 0x02800c0c, mode = 1 -> data = 0,0,0,0,0,0,c,1,c,0,c,0,0,8,2,0 over 16 cycles, frame high on the first beat only, then idle zeros.
REQ-033 Scenario 2: mode = 0 and mode = 3, pc = 0x00000abc -> 8 beats c,b,a,0,0,0,0,0, then busy = 0.
REQ-034 Scenario 3: six distinct nonzero PCs on consecutive cycles with mode = 2 -> four records are sent back-to-back (96 beats, 4 frame pulses) and drop_cnt = 2.
REQ-035 Scenario 4: PC held constant for 100 cycles -> exactly one record. PC stepping to 0 -> no record, and a later return to the previous PC produces a new record.
REQ-036 Scenario 5: rst_n low at beat 5 of a mode-2 record -> data, frame, busy and drop_cnt are 0 before the next edge. After release with PC unchanged and nonzero, exactly one new record is sent.
REQ-037 Scenario 6: mode toggled 1 -> 2 during a mode-1 record -> that record still ends after 16 beats, and the next record uses 24 beats.

Source files
------------

// File: rtl/debug_trace_serializer.sv
// debug_trace_serializer: buffers writeback trace records in a FIFO and streams them out LSB-first in OUT_W-bit beats.
module debug_trace_serializer #(
  parameter int OUT_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [31:0]       debug_wb_pc,
  input  logic [31:0]       debug_wb_instr,
  input  logic [31:0]       debug_wb_rf_wdata,
  output logic [OUT_W-1:0]  data,
  output logic              frame,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BPF = 32 / OUT_W;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [95:0] rec_mem [FIFO_DEPTH];
  logic [1:0] mode_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [6:0] beat_q, beat_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic frame_q, frame_d, busy_q, busy_d;
  logic [95:0] nxt;
  logic push, pop, wr_en, cont;
  function automatic logic [6:0] beats(input logic [1:0] m);
    return 7'((m == 2'd1 ? 2 : m == 2'd2 ? 3 : 1) * BPF);
  endfunction
  always_comb begin
    push      = debug_wb_pc != last_pc_q && debug_wb_pc != 32'd0;
    last_pc_d = debug_wb_pc;
    pop       = state_q == SEND && beat_q == beats(mode_mem[rd_q]) - 7'd1;
    cont      = state_q == SEND && !pop;
    wr_en     = push && (cnt_q < (AW+1)'(FIFO_DEPTH) || pop);
    wr_d      = wr_q + AW'(wr_en);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    drop_d    = push && !wr_en && drop_q != '1 ? drop_q + 1'b1 : drop_q;
    // Head after this edge; an empty FIFO being written this edge forwards the incoming record.
    nxt       = wr_en && wr_q == rd_d ? {debug_wb_rf_wdata, debug_wb_instr, debug_wb_pc} : rec_mem[rd_d];
    state_d   = cont || cnt_d != '0 ? SEND : IDLE;
    beat_d    = cont ? beat_q + 7'd1 : 7'd0;
    busy_d    = state_d == SEND;
    frame_d   = busy_d && beat_d == 7'd0;
    data_d    = busy_d ? nxt[int'(beat_d)*OUT_W +: OUT_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rec_mem[wr_q]  <= {debug_wb_rf_wdata, debug_wb_instr, debug_wb_pc};
      mode_mem[wr_q] <= mode;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      last_pc_q <= '0;
      drop_q    <= '0;
      data_q    <= '0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      last_pc_q <= last_pc_d;
      drop_q    <= drop_d;
      data_q    <= data_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
    end
  end
  assign data     = data_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_debug_trace_serializer.sv
// tb_debug_trace_serializer: scoreboard bench for the trace serializer at OUT_W=4, FIFO_DEPTH=4.
module tb_debug_trace_serializer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] mode = '0;
  logic [31:0] pc = '0, instr = '0, wdata = '0;
  logic [3:0] data;
  logic frame, busy;
  logic [15:0] drop_cnt;
  int tests = 0, fails = 0;
  typedef struct {logic [3:0] d; logic f; logic l;} beat_t;
  beat_t exp_q[$];
  int occ = 0, n_frames = 0, n_beats = 0, bidx = 0;
  logic [31:0] mlast = '0;
  logic [15:0] mdrop = '0;
  logic [95:0] cap = '0;
  debug_trace_serializer #(.OUT_W(4), .FIFO_DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .debug_wb_pc(pc), .debug_wb_instr(instr),
    .debug_wb_rf_wdata(wdata), .data(data), .frame(frame), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    beat_t e;
    logic last_now;
    if (!rst_n) begin
      exp_q.delete();
      occ = 0;
      mlast = '0;
      mdrop = '0;
    end else begin
      last_now = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("busy", 64'(busy), 64'd1);
        check("data", 64'(data), 64'(e.d));
        check("frame", 64'(frame), 64'(e.f));
        last_now = e.l;
      end else begin
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_data", 64'(data), 64'd0);
        check("idle_frame", 64'(frame), 64'd0);
      end
      if (busy) begin
        if (frame) begin
          bidx = 0;
          cap = '0;
          n_frames++;
        end
        cap[bidx*4 +: 4] = data;
        bidx++;
        n_beats++;
      end
      if (pc != mlast && pc != 0) begin
        if (occ < 4 || last_now) begin
          logic [95:0] r;
          int nb;
          r = {wdata, instr, pc};
          nb = (mode == 2'd1 ? 2 : mode == 2'd2 ? 3 : 1) * 8;
          for (int k = 0; k < nb; k++) exp_q.push_back('{r[k*4 +: 4], k == 0, k == nb - 1});
          occ++;
        end else if (mdrop != 16'hffff) mdrop++;
      end
      if (last_now) occ--;
      mlast = pc;
    end
  end
  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic [31:0] w, input logic [1:0] m);
    @(posedge clk);
    #1;
    pc = p;
    instr = i;
    wdata = w;
    mode = m;
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
      done = exp_q.size() == 0 && !busy;
    end
    if (!done) check("timeout", 64'd1, 64'd0);
  endtask
  initial begin
    int f0, b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 64'(data), 64'd0);
    check("rst_frame", 64'(frame), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    f0 = n_frames; b0 = n_beats;
    drive(32'h1c000000, 32'h02800c0c, 32'hdeadbeef, 2'd1);
    wait_idle();
    check("s1_frames", 64'(n_frames - f0), 64'd1);
    check("s1_beats", 64'(n_beats - b0), 64'd16);
    check("s1_stream", cap[63:0], 64'h02800c0c_1c000000);
    f0 = n_frames; b0 = n_beats;
    drive(32'h00000abc, 32'h11111111, 32'h22222222, 2'd0);
    wait_idle();
    check("s2_m0_stream", cap[63:0], 64'h0000_0abc);
    drive(32'h0, 32'h0, 32'h0, 2'd0);
    drive(32'h00000abc, 32'h33333333, 32'h44444444, 2'd3);
    wait_idle();
    check("s2_frames", 64'(n_frames - f0), 64'd2);
    check("s2_beats", 64'(n_beats - b0), 64'd16);
    check("s2_m3_stream", cap[63:0], 64'h0000_0abc);
    f0 = n_frames; b0 = n_beats;
    for (int i = 1; i <= 6; i++) drive(32'(i * 256), 32'(i * 17), 32'(i * 4099), 2'd2);
    wait_idle();
    check("s3_frames", 64'(n_frames - f0), 64'd4);
    check("s3_beats", 64'(n_beats - b0), 64'd96);
    check("s3_drop", 64'(drop_cnt), 64'd2);
    check("s3_drop_model", 64'(drop_cnt), 64'(mdrop));
    f0 = n_frames;
    drive(32'h00002000, 32'h5, 32'h6, 2'd0);
    repeat (100) @(posedge clk);
    wait_idle();
    check("s4_hold", 64'(n_frames - f0), 64'd1);
    drive(32'h0, 32'h0, 32'h0, 2'd0);
    repeat (20) @(posedge clk);
    check("s4_zero", 64'(n_frames - f0), 64'd1);
    drive(32'h00002000, 32'h7, 32'h8, 2'd0);
    wait_idle();
    check("s4_return", 64'(n_frames - f0), 64'd2);
    drive(32'h00003000, 32'habcdef01, 32'h12345678, 2'd2);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("s5_data", 64'(data), 64'd0);
    check("s5_frame", 64'(frame), 64'd0);
    check("s5_busy", 64'(busy), 64'd0);
    check("s5_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = n_frames; b0 = n_beats;
    wait_idle();
    check("s5_frames", 64'(n_frames - f0), 64'd1);
    check("s5_beats", 64'(n_beats - b0), 64'd24);
    check("s5_stream_hi", cap[95:32], 64'h12345678_abcdef01);
    f0 = n_frames; b0 = n_beats;
    drive(32'h00004000, 32'h9, 32'ha, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    mode = 2'd2;
    drive(32'h00005000, 32'hb, 32'hc, 2'd2);
    wait_idle();
    check("s6_frames", 64'(n_frames - f0), 64'd2);
    check("s6_beats", 64'(n_beats - b0), 64'd40);
    check("s6_drop", 64'(drop_cnt), 64'(mdrop));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
